// File: rtl/sram_controller.sv
// Memory-stage controller that performs each 32-bit load/store as two 16-bit
// transactions on an asynchronous SRAM, holding ready low while an access runs.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          ADDR_W      = 18,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_next_cnt;
  logic                r_op_write;
  logic [ADDR_W-2:0]   r_index;
  logic [31:0]         r_wdata;
  logic [31:0]         r_read_data;
  logic [ADDR_W-1:0]   r_sram_addr;
  logic [15:0]         r_dq_out;

  logic                w_req;
  logic                w_last;
  logic                w_busy;
  logic [31:0]         w_offset;
  logic [ADDR_W-2:0]   w_index;
  logic                w_unused_bits;

  assign w_req    = mem_read | mem_write;
  assign w_last   = (r_cnt == CNT_LAST);
  assign w_busy   = (r_state == LO) || (r_state == HI);
  // Halfword-pair index; upper bits drop off so out-of-range addresses wrap.
  assign w_offset = address - BASE_ADDR;
  assign w_index  = w_offset[ADDR_W:2];
  assign w_unused_bits = &{1'b0, w_offset[31:ADDR_W+1], w_offset[1:0]};

  assign read_data   = r_read_data;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    sram_we_n    = 1'b1;
    sram_dq_oe   = 1'b0;
    ready        = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next_state = LO;
          w_next_cnt   = '0;
          ready        = 1'b0;
        end
      end
      LO, HI: begin
        ready      = 1'b0;
        sram_we_n  = ~r_op_write;
        sram_dq_oe = r_op_write;
        if (w_last) begin
          w_next_state = (r_state == LO) ? HI : DONE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      DONE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    // The state may not yet reflect an asserted reset during the reset cycle.
    if (!rst) ready = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_write  <= 1'b0;
      r_index     <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_op_write  <= mem_write;
            r_index     <= w_index;
            r_wdata     <= write_data;
            r_sram_addr <= {w_index, 1'b0};
            if (mem_write) r_dq_out <= write_data[15:0];
          end
        end
        LO: begin
          if (w_last) begin
            r_sram_addr <= {r_index, 1'b1};
            if (r_op_write) r_dq_out <= r_wdata[31:16];
            else            r_read_data[15:0] <= sram_dq_in;
          end
        end
        HI: begin
          if (w_last && !r_op_write) r_read_data[31:16] <= sram_dq_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage data-memory controller sitting directly downstream of the EXE/MEM pipeline register. It takes the registered memory request (read/write enable, ALU-computed address, store data) and performs each 32-bit access as two 16-bit transactions on an external asynchronous SRAM. While an access is in progress it holds `ready` low so the pipeline freezes. Load data is returned to the MEM/WB path when the access completes.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `ADDR_W`, 18: SRAM address width (16-bit halfword locations).
- `WAIT_CYCLES`, 2: cycles each halfword phase is held on the SRAM bus (≥1).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  load request from the EXE/MEM register.
- `mem_write`  in  1  store request from the EXE/MEM register.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (Rm value).
- `read_data`  out  32  load result; holds the last completed read.
- `ready`  out  1  0 = access in progress, freeze the pipeline.
- `sram_addr`  out  ADDR_W  SRAM halfword address.
- `sram_dq_out`  out  16  write data to the SRAM.
- `sram_dq_in`  in  16  read data from the SRAM.
- `sram_dq_oe`  out  1  1 = controller drives the DQ bus.
- `sram_we_n`  out  1  active-low SRAM write enable.

## Operation
- States: IDLE, LO, HI, DONE. A phase counter `cnt` counts 0..WAIT_CYCLES-1 within LO and HI.
- IDLE:
  - If `mem_write|mem_read` is high, latch `op` (write if `mem_write`, else read), word index and `write_data`; go to LO with `cnt`=0.
  - If both enables are high, the write wins and the read is ignored.
- Word index = (`address` − `BASE_ADDR`) >> 2, truncated to ADDR_W−1 bits. Out-of-range addresses wrap modulo 2^(ADDR_W−1). `address[1:0]` is ignored.
- LO:
  - Drive `sram_addr` = {index,1'b0}.
  - On a write: `sram_dq_out` = data[15:0], `sram_dq_oe`=1, `sram_we_n`=0.
  - On a read: `sram_dq_oe`=0, `sram_we_n`=1, and on the edge ending the last LO cycle, capture `sram_dq_in` into `read_data[15:0]`.
  - After WAIT_CYCLES cycles go to HI.
- HI: same as LO, with `sram_addr` = {index,1'b1} and data[31:16] / `read_data[31:16]`. After WAIT_CYCLES cycles go to DONE.
- DONE: bus idle (`sram_we_n`=1, `sram_dq_oe`=0). Lasts one cycle, then returns to IDLE unconditionally.
- `ready` (combinational):
  - 0 in IDLE with a request pending, and throughout LO and HI.
  - 1 in DONE, and in IDLE with no request.
  - The pipeline advances on the DONE edge, so the same request is not restarted.
- `read_data` changes only during a read; writes leave it untouched.
- Bus idle values outside LO/HI: `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr` holds its last value, `sram_dq_out` holds its last value.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `cnt`=0, `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, `ready`=1 regardless of inputs.
- Reset asserted mid-access aborts the access immediately. A partially captured `read_data` is cleared to 0.
- Request visible in cycle 0 (IDLE):
  - Cycles 1..W: LO.
  - Cycles W+1..2W: HI.
  - Cycle 2W+1: DONE.
- `ready` is low for 2W+1 cycles and high in cycle 2W+1. With W=2: low for cycles 0–4, high in cycle 5.
- `read_data` is valid from the start of DONE and stable until the next read's LO capture.
- `sram_we_n` is low for exactly W cycles per half on a write. `sram_addr` and `sram_dq_out` are stable for the whole phase.
- Inputs are sampled only in IDLE. Changes during LO/HI/DONE have no effect.
- Back-to-back requests: the next request is accepted in the IDLE cycle following DONE. Minimum period is 2W+2 cycles.

## Test plan
- **Reset values:** assert `rst`=0 with `mem_write`=1 → `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0, `read_data`=0. Release reset → the access starts in the next cycle.
- **Write:** `mem_write`=1, `address`=1024+8, `write_data`=0xDEADBEEF, W=2 →
  - Cycles 1–2: `sram_addr`=4, dq=0xBEEF, `we_n`=0.
  - Cycles 3–4: `sram_addr`=5, dq=0xDEAD, `we_n`=0.
  - `ready`=0 for cycles 0–4, 1 in cycle 5.
- **Read back:** SRAM model returns the stored halves for the same address → `read_data`=0xDEADBEEF in cycle 5, `ready`=1, and `read_data` held through a following write.
- **Simultaneous enables and wrap-around:**
  - `mem_read`=`mem_write`=1 at `address`=1024+4 → a write is performed (`we_n` pulses).
  - `address`=1024+(1<<19)+4 → `sram_addr`=2/3 (wrap).
- **Reset mid-read:** assert `rst` in cycle 3 of a read → outputs return to reset values asynchronously, and a fresh read after release completes in 2W+1 cycles.
- **Back-to-back with WAIT_CYCLES=1:** two consecutive reads →
  - `ready` pattern 0,0,0,1 per access.
  - Second access starts exactly one cycle after DONE.
  - Both `read_data` values are correct.
